// File: rtl/branch_unit.sv
// rtl/branch_unit.sv - branch decision and return-address stack for the 6-bit PC
module branch_unit #(
  parameter int AW    = 6,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          br_valid,
  input  logic [2:0]    br_op,
  input  logic [AW-1:0] br_tgt,
  input  logic          zero,
  input  logic          carry,
  input  logic [AW-1:0] pcin,
  output logic          jmp,
  output logic [AW-1:0] jmpAdrs,
  output logic [3:0]    depth,
  output logic          ovf,
  output logic          unf
);

  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [2:0] OP_JMP  = 3'b001;
  localparam logic [2:0] OP_JZ   = 3'b010;
  localparam logic [2:0] OP_JNZ  = 3'b011;
  localparam logic [2:0] OP_JC   = 3'b100;
  localparam logic [2:0] OP_CALL = 3'b101;
  localparam logic [2:0] OP_RET  = 3'b110;

  logic [AW-1:0] stack [DEPTH];

  logic          active;
  logic          stackFull;
  logic          stackEmpty;
  logic          callTaken;
  logic          callFull;
  logic          retTaken;
  logic          retEmpty;
  logic [IW-1:0] pushIdx;
  logic [IW-1:0] topIdx;

  assign active     = br_valid && !rst;
  assign stackFull  = (depth == 4'(DEPTH));
  assign stackEmpty = (depth == 4'd0);
  assign pushIdx    = IW'(depth);
  assign topIdx     = IW'(depth - 4'd1);

  assign callTaken  = active && (br_op == OP_CALL) && !stackFull;
  assign callFull   = active && (br_op == OP_CALL) && stackFull;
  assign retTaken   = active && (br_op == OP_RET) && !stackEmpty;
  assign retEmpty   = active && (br_op == OP_RET) && stackEmpty;

  // Not-taken ops and reset both leave the address bus at zero.
  always_comb begin
    jmp     = 1'b0;
    jmpAdrs = '0;
    if (active) begin
      case (br_op)
        OP_JMP:  jmp = 1'b1;
        OP_JZ:   jmp = zero;
        OP_JNZ:  jmp = !zero;
        OP_JC:   jmp = carry;
        OP_CALL: jmp = callTaken;
        OP_RET:  jmp = retTaken;
        default: jmp = 1'b0;
      endcase
      if (jmp) begin
        jmpAdrs = (br_op == OP_RET) ? stack[topIdx] : br_tgt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= 4'd0;
      ovf   <= 1'b0;
      unf   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stack[i] <= '0;
      end
    end else begin
      if (callTaken) begin
        stack[pushIdx] <= pcin + AW'(1);
        depth          <= depth + 4'd1;
      end
      // The popped slot keeps its value; only depth moves.
      if (retTaken) begin
        depth <= depth - 4'd1;
      end
      if (callFull) begin
        ovf <= 1'b1;
      end
      if (retEmpty) begin
        unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_branch_unit.sv
// tb/tb_branch_unit.sv - scoreboard bench for branch_unit against a queue-based return-stack model
module tb_branch_unit;

  localparam int AW    = 6;
  localparam int DEPTH = 4;

  localparam logic [2:0] NONE = 3'd0, JMP = 3'd1, JZ = 3'd2, JNZ = 3'd3,
                         JC = 3'd4, CALL = 3'd5, RET = 3'd6, RSV = 3'd7;

  logic          clk = 1'b0;
  logic          rst;
  logic          br_valid;
  logic [2:0]    br_op;
  logic [AW-1:0] br_tgt;
  logic          zero;
  logic          carry;
  logic [AW-1:0] pcin;
  logic          jmp;
  logic [AW-1:0] jmpAdrs;
  logic [3:0]    depth;
  logic          ovf;
  logic          unf;

  typedef struct {
    int jmp;
    int adrs;
    int depth;
    int ovf;
    int unf;
  } expect_t;

  expect_t sb[$];
  int      retStack[$];
  int      mOvf;
  int      mUnf;
  int      checks = 0;
  int      errors = 0;

  branch_unit #(.AW(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .br_valid(br_valid), .br_op(br_op), .br_tgt(br_tgt),
    .zero(zero), .carry(carry), .pcin(pcin), .jmp(jmp), .jmpAdrs(jmpAdrs),
    .depth(depth), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  // One cycle of stimulus: drive, predict this cycle's outputs, then advance the model past the edge.
  task automatic step(input logic r, input logic v, input logic [2:0] op, input int tgt,
                      input logic z, input logic c, input int pc);
    expect_t e;
    bit      en;
    bit      taken;
    rst = r; br_valid = v; br_op = op; br_tgt = AW'(tgt);
    zero = z; carry = c; pcin = AW'(pc);
    en = !r && v;
    taken = 0;
    if (en) begin
      if (op == JMP) taken = 1;
      else if (op == JZ) taken = z;
      else if (op == JNZ) taken = !z;
      else if (op == JC) taken = c;
      else if (op == CALL) taken = retStack.size() < DEPTH;
      else if (op == RET) taken = retStack.size() > 0;
    end
    e.jmp   = taken ? 1 : 0;
    e.adrs  = !taken ? 0 : (op == RET) ? retStack[$] : tgt % 64;
    e.depth = retStack.size();
    e.ovf   = mOvf;
    e.unf   = mUnf;
    sb.push_back(e);
    @(posedge clk);
    if (r) begin
      retStack.delete();
      mOvf = 0;
      mUnf = 0;
    end else if (en && op == CALL) begin
      if (retStack.size() == DEPTH) mOvf = 1;
      else retStack.push_back((pc + 1) % 64);
    end else if (en && op == RET) begin
      if (retStack.size() == 0) mUnf = 1;
      else void'(retStack.pop_back());
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      expect_t e;
      e = sb.pop_front();
      check("jmp", int'(jmp), e.jmp);
      check("jmpAdrs", int'(jmpAdrs), e.adrs);
      check("depth", int'(depth), e.depth);
      check("ovf", int'(ovf), e.ovf);
      check("unf", int'(unf), e.unf);
    end
  end

  initial begin
    rst = 1; br_valid = 0; br_op = NONE; br_tgt = 0; zero = 0; carry = 0; pcin = 0;
    mOvf = 0; mUnf = 0;
    repeat (2) @(posedge clk);
    #1;

    step(1, 1, JMP, 'h15, 0, 0, 0);
    step(0, 1, JZ,  'h20, 1, 0, 3);
    step(0, 1, JZ,  'h20, 0, 0, 4);
    step(0, 1, JNZ, 'h20, 0, 0, 5);
    step(0, 1, JNZ, 'h20, 1, 0, 6);
    step(0, 1, JC,  'h07, 0, 1, 7);
    step(0, 1, JC,  'h07, 0, 0, 8);
    step(0, 0, JMP, 'h11, 0, 0, 9);
    step(0, 1, RSV, 'h11, 1, 1, 9);

    step(0, 1, CALL, 'h30, 0, 0, 'h05);
    step(0, 1, RET,  'h00, 0, 0, 'h30);
    step(0, 1, CALL, 'h10, 0, 0, 'h3F);
    step(0, 1, RET,  'h00, 0, 0, 'h10);

    step(0, 1, CALL, 'h11, 0, 0, 'h01);
    step(0, 1, CALL, 'h21, 0, 0, 'h11);
    step(0, 1, CALL, 'h31, 0, 0, 'h21);
    step(0, 1, CALL, 'h01, 0, 0, 'h31);
    step(0, 1, CALL, 'h2A, 0, 0, 'h01);
    for (int i = 0; i < 5; i++) step(0, 1, RET, 0, 0, 0, 'h20 + i);
    step(0, 1, JMP, 'h0C, 0, 0, 0);

    step(0, 1, CALL, 'h08, 0, 0, 'h02);
    step(0, 1, CALL, 'h18, 0, 0, 'h08);
    step(0, 1, CALL, 'h28, 0, 0, 'h18);
    step(1, 1, CALL, 'h38, 0, 0, 'h28);
    step(0, 1, RET,  'h00, 0, 0, 'h00);
    step(0, 1, NONE, 'h00, 0, 0, 'h01);

    for (int i = 0; i < 400; i++) begin
      logic [2:0] op;
      op = (i % 3 == 0) ? (($urandom_range(0, 1) == 0) ? CALL : RET) : 3'($urandom_range(0, 7));
      step(($urandom_range(0, 49) == 0), ($urandom_range(0, 7) != 0), op,
           int'($urandom_range(0, 63)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           int'($urandom_range(0, 63)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_unit.md
# branch_unit

Control-flow source for the 6-bit program counter. Each cycle it evaluates a decoded branch operation against the ALU flags and drives `jmp`/`jmpAdrs`, which the PC samples on the same clock edge. A return-address stack supports CALL/RET. Underflow and overflow are reported through sticky error flags.

## Interface
- `AW`, 6: address width; must match the PC width.
- `DEPTH`, 4: return-stack entries, 1..8.
- `clk`  in  1: single system clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `br_valid`  in  1: current `br_op` is valid. When low, it is treated as NONE.
- `br_op`  in  3: 000 NONE, 001 JMP, 010 JZ, 011 JNZ, 100 JC, 101 CALL, 110 RET, 111 reserved (treated as NONE).
- `br_tgt`  in  AW: target address for JMP/JZ/JNZ/JC/CALL.
- `zero`  in  1: ALU zero flag.
- `carry`  in  1: ALU carry flag.
- `pcin`  in  AW: current PC value (PC `pcout`).
- `jmp`  out  1: load `jmpAdrs` into the PC at the next edge.
- `jmpAdrs`  out  AW: jump destination.
- `depth`  out  4: number of valid stack entries, 0..DEPTH.
- `ovf`  out  1: sticky flag; a CALL was attempted with the stack full.
- `unf`  out  1: sticky flag; a RET was attempted with the stack empty.

## Operation
- `jmp` and `jmpAdrs` are combinational from the inputs and the stack top. No registered delay, so the PC takes the jump on the edge that ends the cycle.
- Taken conditions:
  - JMP: always.
  - JZ: `zero`=1.
  - JNZ: `zero`=0.
  - JC: `carry`=1.
  - CALL: `depth`<DEPTH.
  - RET: `depth`>0.
- Destination: `br_tgt` for every op except RET, which uses `stack[depth-1]`.
- Not-taken or NONE: `jmp`=0 and `jmpAdrs`=0.
- CALL taken: at the edge, push `pcin+1` (mod 2^AW, so 63 wraps to 0) and increment `depth`.
- CALL when full: `jmp`=0, no push, and `ovf` is set at the edge.
- RET taken: at the edge, pop (decrement `depth`). The popped entry is not cleared.
- RET when empty: `jmp`=0 and `unf` is set at the edge.
- `ovf` and `unf` clear only on `rst`. While either is set, the block keeps operating normally.
- The stack is a register array indexed by `depth`. Nothing else is stored: no pointer besides `depth`, and no FSM beyond the stack and the flags.

## Timing
- Reset: while `rst`=1, `jmp`=0 and `jmpAdrs`=0 (forced, regardless of inputs). At the edge, `depth`=0, `ovf`=0, `unf`=0 and all stack entries become 0.
- `rst` overrides any op in the same cycle: no push, no pop, no flag update. A reset mid-sequence discards all pending returns.
- Branch latency: decision in cycle n, PC holds the target after edge n.
- Push/pop are visible to the next cycle: CALL in cycle n followed by RET in cycle n+1 returns to `pcin(n)+1`.
- `depth`, `ovf`, `unf` are registered and change only at the edge.
- Back-to-back CALLs fill the stack in order. RETs return LIFO.
- Flags and `pcin` are sampled in the same cycle as `br_op`; their setup and hold follow the `clk` domain.

## Test plan
- Reset: hold `rst` with `br_op`=JMP and `br_tgt`=0x15 → `jmp`=0, `jmpAdrs`=0, `depth`=0, `ovf`=0, `unf`=0.
- Conditionals:
  - JZ to 0x20: `zero`=1 → `jmp`=1, `jmpAdrs`=0x20; `zero`=0 → `jmp`=0.
  - JNZ: the inverse of JZ.
  - JC to 0x07 with `carry`=1 → `jmp`=1; with `carry`=0 → `jmp`=0.
  - `br_valid`=0 with JMP → `jmp`=0.
- Call/return with the PC: CALL 0x30 at `pcin`=0x05 → next cycle `depth`=1 and the PC is at 0x30. RET → `jmpAdrs`=0x06, then `depth`=0. CALL at `pcin`=0x3F pushes 0x00.
- Nesting: CALLs from `pcin`=0x01, 0x11, 0x21, 0x31 → `depth`=4. RETs yield 0x32, 0x22, 0x12, 0x02, in that order.
- Overflow and underflow:
  - A fifth CALL → `jmp`=0, `ovf`=1, `depth` stays 4.
  - After draining, an extra RET → `jmp`=0, `unf`=1.
  - Both flags stay set until `rst`.
- Reset mid-stack: with `depth`=3, assert `rst` in the same cycle as a CALL → `depth`=0 and no push. A following RET sets `unf`.
